// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin share of one pipelined 16x16 signed multiplier
// Optional MUL_ARB_PRIO0_EN: requester 0 gets strict priority, others rotate among 1..NUM_REQ-1.
module mul_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [16*NUM_REQ-1:0]   req_a,
    input  logic [16*NUM_REQ-1:0]   req_b,
    output logic                    mul_ce,
    output logic [15:0]             mul_din0,
    output logic [15:0]             mul_din1,
    input  logic [30:0]             mul_dout,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ID_W-1:0]         res_id,
    output logic [30:0]             res_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [MUL_LAT-1:0] r_tag_v;
    logic [ID_W-1:0]    r_tag_id [MUL_LAT];
    logic [ID_W-1:0]    r_rr_ptr;

    logic               w_ce;
    logic               w_found;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_id;
    logic [ID_W-1:0]    w_rr_next;
    logic [ID_W-1:0]    w_sel;
    int                 w_idx;

    // A presented but unaccepted result freezes the multiplier and the tag shadow together.
    assign w_ce = ~(r_tag_v[MUL_LAT-1] & ~res_ready);

    always_comb begin
        w_grant    = '0;
        w_grant_id = '0;
        w_found    = 1'b0;
        w_rr_next  = r_rr_ptr;
        w_idx      = 0;
        if (w_ce) begin
`ifdef MUL_ARB_PRIO0_EN
            if (req_valid[0]) begin
                w_found    = 1'b1;
                w_grant[0] = 1'b1;
            end else begin
                // rr_ptr of 0 (reset value) is treated as the start of the 1..NUM_REQ-1 ring
                for (int k = 0; k < NUM_REQ - 1; k++) begin
                    if (!w_found) begin
                        w_idx = 1 + ((((r_rr_ptr == '0) ? 1 : int'(r_rr_ptr)) - 1 + k) % (NUM_REQ - 1));
                        if (req_valid[IDX_W'(w_idx)]) begin
                            w_found                = 1'b1;
                            w_grant[IDX_W'(w_idx)] = 1'b1;
                            w_grant_id             = ID_W'(w_idx);
                            w_rr_next              = (w_idx == NUM_REQ - 1) ? ID_W'(1) : ID_W'(w_idx + 1);
                        end
                    end
                end
            end
`else
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!w_found) begin
                    w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
                    if (req_valid[IDX_W'(w_idx)]) begin
                        w_found                = 1'b1;
                        w_grant[IDX_W'(w_idx)] = 1'b1;
                        w_grant_id             = ID_W'(w_idx);
                        w_rr_next              = ID_W'((w_idx + 1) % NUM_REQ);
                    end
                end
            end
`endif
        end
    end

    // Idle cycles still present a real requester's operands so the multiplier never sees X.
    assign w_sel = w_found ? w_grant_id : r_rr_ptr;

    always_comb begin
        mul_din0 = '0;
        mul_din1 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == ID_W'(i)) begin
                mul_din0 = req_a[16*i +: 16];
                mul_din1 = req_b[16*i +: 16];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tag_v  <= '0;
            r_rr_ptr <= '0;
            for (int k = 0; k < MUL_LAT; k++) begin
                r_tag_id[k] <= '0;
            end
        end else if (w_ce) begin
            r_tag_v[0]  <= w_found;
            r_tag_id[0] <= w_grant_id;
            for (int k = 1; k < MUL_LAT; k++) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_id[k] <= r_tag_id[k-1];
            end
            r_rr_ptr <= w_rr_next;
        end
    end

    assign req_ready = w_grant;
    assign mul_ce    = w_ce;
    assign res_valid = r_tag_v[MUL_LAT-1];
    assign res_id    = r_tag_id[MUL_LAT-1];
    assign res_data  = mul_dout;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - directed self-checking bench for mul_share_arbiter
module tb_mul_share_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        mul_ce;
    logic [15:0] mul_din0;
    logic [15:0] mul_din1;
    logic [30:0] mul_dout;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic [30:0] res_data;

    int total = 0;
    int bad   = 0;

    mul_share_arbiter #(.NUM_REQ(4), .ID_W(2), .MUL_LAT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_ce    (mul_ce),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_data  (res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 4-stage ce-gated multiplier, intentionally not reset.
    logic signed [31:0] m_prod;
    logic [30:0]        m_pipe [4];
    assign m_prod   = $signed(mul_din0) * $signed(mul_din1);
    assign mul_dout = m_pipe[3];
    always @(posedge clk) begin
        if (mul_ce) begin
            m_pipe[0] <= m_prod[30:0];
            for (int k = 1; k < 4; k++) m_pipe[k] <= m_pipe[k-1];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] e31(input int v);
        return {1'b0, v[30:0]};
    endfunction

    task automatic set_op(input int i, input int a, input int b);
        req_a[16*i +: 16] = 16'(a);
        req_b[16*i +: 16] = 16'(b);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    int          t2_exp [4] = '{6, -20, -10000, -7};
    int          t4a [3]    = '{-32768, 32767, 0};
    int          t4b [3]    = '{-32768, -32768, 1234};
    logic [31:0] t4e [3]    = '{32'h4000_0000, 32'h4000_8000, 32'h0};
    logic [3:0]  t5_rdy [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001};
    logic [3:0]  pr_rdy [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};
    int          k_iss;
    int          r_got;

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;

        @(negedge clk); #1;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_mul_ce", 32'(mul_ce), 32'd1);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // single requester, 3 * -5
        set_op(0, 3, -5);
        req_valid = 4'b0001;
        #1;
        chk("t1_rdy", 32'(req_ready), 32'h1);
        chk("t1_din0", 32'(mul_din0), 32'h0003);
        chk("t1_din1", 32'(mul_din1), 32'hFFFB);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            if (c < 4) begin
                chk("t1_early_valid", 32'(res_valid), 32'd0);
            end else begin
                chk("t1_valid", 32'(res_valid), 32'd1);
                chk("t1_id", 32'(res_id), 32'd0);
                chk("t1_data", 32'(res_data), e31(-15));
            end
        end
        @(negedge clk); #1;
        chk("t1_after_valid", 32'(res_valid), 32'd0);

`ifndef MUL_ARB_PRIO0_EN
        // all four requesters valid, full throughput
        pulse_reset();
        set_op(0, 2, 3);
        set_op(1, -4, 5);
        set_op(2, 100, -100);
        set_op(3, 7, -1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_valid = (c < 6) ? 4'hF : 4'h0;
            #1;
            if (c < 6) chk("t2_rdy", 32'(req_ready), 32'(4'b0001 << (c % 4)));
            if (c >= 4) begin
                chk("t2_valid", 32'(res_valid), 32'd1);
                chk("t2_id", 32'(res_id), 32'((c - 4) % 4));
                chk("t2_data", 32'(res_data), e31(t2_exp[(c - 4) % 4]));
            end
        end
`endif

        // backpressure on a stream from requester 2
        k_iss = 0;
        r_got = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            req_valid = (k_iss < 6) ? 4'b0100 : 4'b0000;
            set_op(2, k_iss + 1, 10);
            res_ready = !(c >= 4 && c <= 6);
            #1;
            if (c >= 4 && c <= 6) begin
                chk("t3_stall_ce", 32'(mul_ce), 32'd0);
                chk("t3_stall_rdy", 32'(req_ready), 32'd0);
                chk("t3_stall_valid", 32'(res_valid), 32'd1);
                chk("t3_stall_id", 32'(res_id), 32'd2);
                chk("t3_stall_data", 32'(res_data), e31(10));
            end
            if (res_valid && res_ready) begin
                chk("t3_id", 32'(res_id), 32'd2);
                chk("t3_data", 32'(res_data), e31((r_got + 1) * 10));
                r_got++;
            end
            if (req_ready[2]) k_iss++;
        end
        res_ready = 1'b1;
        chk("t3_issued", 32'(k_iss), 32'd6);
        chk("t3_results", 32'(r_got), 32'd6);

        // boundary operands from requester 3
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            req_valid = (c < 3) ? 4'b1000 : 4'b0000;
            if (c < 3) set_op(3, t4a[c], t4b[c]);
            #1;
            if (c < 3) chk("t4_rdy", 32'(req_ready), 32'h8);
            if (c >= 4 && c <= 6) begin
                chk("t4_valid", 32'(res_valid), 32'd1);
                chk("t4_id", 32'(res_id), 32'd3);
                chk("t4_data", 32'(res_data), t4e[c - 4]);
            end
        end

`ifndef MUL_ARB_PRIO0_EN
        // reset with products in flight
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req_valid = 4'b0111;
            #1;
            chk("t5_rdy", 32'(req_ready), 32'(t5_rdy[c]));
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("t5_pre_valid", 32'(res_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("t5_async_valid", 32'(res_valid), 32'd0);
        chk("t5_async_ce", 32'(mul_ce), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            chk("t5_stale_valid", 32'(res_valid), 32'd0);
        end
        @(negedge clk);
        req_valid = 4'hF;
        #1;
        chk("t5_rr_restart", 32'(req_ready), 32'h1);
        @(negedge clk); #1;
        chk("t5_rr_next", 32'(req_ready), 32'h2);
        req_valid = '0;
`else
        // strict priority for requester 0
        pulse_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_valid = 4'hF;
            #1;
            chk("pr_rdy0", 32'(req_ready), 32'h1);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req_valid = 4'hE;
            #1;
            chk("pr_rot", 32'(req_ready), 32'(pr_rdy[c]));
        end
        req_valid = '0;
`endif
        for (int c = 0; c < 6; c++) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
